// File: rtl/prescaled_counter.sv
// Up/down counter stepped once every DIV clocks by an internal prescaler.
// Counts in plain binary or as packed BCD digits, with load, clear and wrap flag.
module prescaled_counter #(
    parameter int unsigned DIV   = 50000000,
    parameter int unsigned DIV_W = 26,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BCD   = 0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SCLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TICK,
    output logic             WRAP
);

    localparam int unsigned NDIG  = WIDTH / 4;
    localparam logic [DIV_W-1:0] P_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] p;
    logic             step_c;
    logic [WIDTH-1:0] next_q_c;
    logic             wrap_c;
    logic [WIDTH-1:0] load_val_c;
    logic             carry;
    logic [3:0]       dig;

    assign step_c = EN && (p == P_LAST);

    // Next count value and wrap detection for the current direction
    always_comb begin
        next_q_c = Q;
        wrap_c   = 1'b0;
        carry    = 1'b1;
        dig      = 4'd0;
        if (BCD != 0) begin
            // Digit-serial ripple: each digit only moves while a carry/borrow is pending
            for (int i = 0; i < NDIG; i++) begin
                dig = Q[4*i +: 4];
                if (carry) begin
                    if (UP) begin
                        if (dig >= 4'd9) begin
                            next_q_c[4*i +: 4] = 4'd0;
                        end else begin
                            next_q_c[4*i +: 4] = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            next_q_c[4*i +: 4] = 4'd9;
                        end else begin
                            next_q_c[4*i +: 4] = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_c = carry;
        end else begin
            next_q_c = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
            wrap_c   = UP ? (&Q) : (Q == '0);
        end
    end

    // Load value, with out-of-range BCD digits saturated to 9
    always_comb begin
        load_val_c = D;
        if (BCD != 0) begin
            for (int i = 0; i < NDIG; i++) begin
                if (D[4*i +: 4] > 4'd9) begin
                    load_val_c[4*i +: 4] = 4'd9;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            p    <= '0;
            Q    <= '0;
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end else if (SCLR) begin
            p    <= '0;
            Q    <= '0;
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end else if (LOAD) begin
            p    <= '0;
            Q    <= load_val_c;
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end else if (step_c) begin
            p    <= '0;
            Q    <= next_q_c;
            TICK <= 1'b1;
            WRAP <= wrap_c;
        end else begin
            TICK <= 1'b0;
            WRAP <= 1'b0;
            if (EN) begin
                p <= p + DIV_W'(1);
            end
        end
    end

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
Parametrised up/down counter driven by an internal clock-enable prescaler: counts once every DIV clocks of the board clock. Binary or per-digit BCD counting, synchronous load, synchronous clear, wrap flag. Sits between CLOCK_50 and the hex display drivers, and replaces fixed-width slow counters built from cascaded counters.

Parameters:
DIV, 50000000, clocks per count step; must be >= 1.
DIV_W, 26, prescaler register width; must satisfy 2^DIV_W >= DIV.
WIDTH, 16, counter width in bits; must be a multiple of 4 when BCD=1.
BCD, 0, 0 = binary count; 1 = each nibble is a decimal digit 0-9 with carry/borrow.

Ports:
CLK  input  1  system clock (CLOCK_50 at top level)
CLR_N  input  1  asynchronous reset, active-low
SCLR  input  1  synchronous clear, active-high
EN  input  1  count enable; freezes prescaler and counter when low
UP  input  1  1 = count up, 0 = count down; sampled on the step edge
LOAD  input  1  synchronous load of D
D  input  WIDTH  load value
Q  output  WIDTH  counter value, registered
TICK  output  1  one-cycle pulse, high in the cycle after each count step
WRAP  output  1  one-cycle pulse, high in the cycle after a step that wrapped Q

Behaviour:
- Reset: the clock and reset are fixed. CLR_N low forces P (prescaler) = 0, Q = 0, TICK = 0, WRAP = 0 immediately, independent of CLK. Release is synchronous to the next CLK edge.
- Priority on each CLK rising edge: SCLR > LOAD > step > hold.
- SCLR=1: P <= 0, Q <= 0, TICK <= 0, WRAP <= 0. Ignores EN, LOAD and UP.
- LOAD=1 (SCLR=0): Q <= D, P <= 0, TICK <= 0, WRAP <= 0. Ignores EN.
  - BCD=1: any nibble of D greater than 9 loads as 9.
- Prescaler: with EN=1, P increments each edge. An edge with P == DIV-1 is a step edge; P <= 0 on that edge.
  - DIV=1: every enabled edge is a step edge.
- Step edge: Q <= next(Q, UP); TICK <= 1; WRAP <= 1 iff the step wrapped.
- Non-step edges: TICK <= 0 and WRAP <= 0.
- EN=0 (no SCLR or LOAD): P and Q hold; TICK and WRAP go 0. Re-enabling continues the partial prescale; the count does not restart.
- Binary next():
  - Up: Q+1 mod 2^WIDTH; wrap when Q = all-ones.
  - Down: Q-1 mod 2^WIDTH; wrap when Q = 0.
- BCD next(): digit-serial with ripple carry/borrow within one cycle.
  - Up: a digit at 9 becomes 0 and carries. Wrap when all digits are 9; result is 0.
  - Down: a digit at 0 becomes 9 and borrows. Wrap when Q = 0; result is all digits 9.
- UP changing between step edges has no effect until the next step edge.
- Latency: Q changes on the step edge. TICK and WRAP are asserted for exactly one CLK cycle following it.
- TICK and WRAP are never high while CLR_N is low, or in the cycle after an SCLR or LOAD edge.

Test Plan:
- Async reset: DIV=4, WIDTH=8, counting with Q=0x23. Drop CLR_N between edges -> Q=0x00, TICK=0, WRAP=0 before the next edge. After release, the first TICK comes 4 enabled edges later.
- Binary up wrap: DIV=4, LOAD D=0xFE, then EN=1, UP=1.
  - Q=0xFF after 4 edges, then 0x00 after 8 edges.
  - TICK is high in cycles 5 and 9; WRAP is high only in cycle 9.
- Binary down wrap: LOAD D=0x01, UP=0 -> Q=0x00, then 0xFF with a WRAP pulse. The DIV=1 variant steps every edge.
- BCD (BCD=1, WIDTH=8, DIV=1):
  - LOAD 0x09, up -> 0x10.
  - LOAD 0x99, up -> 0x00 with WRAP.
  - LOAD 0x10, down -> 0x09.
  - LOAD 0x00, down -> 0x99 with WRAP.
  - LOAD 0xAF -> Q=0x99.
- Priority (DIV=4):
  - SCLR and LOAD together on a step edge -> Q=0, no TICK.
  - LOAD alone on the step edge -> Q=D, P restarts, next TICK 4 edges later.
- Enable hold: DIV=4, EN low after 2 enabled edges, for 10 cycles -> Q unchanged, no TICK. After EN returns high, the step occurs on the 2nd enabled edge.
